// File: rtl/bmnc_defs.sv
// ---------------------------------------------------------------------------
// bmnc_defs
// Shared definitions for the bitonic merge network (BMNC) front-end blocks.
//   - default geometry (N, log_N, elements_width), also used by BMNC_random
//   - loader FSM state encodings
//   - element slice-offset helper: element k starts at bit k*elements_width
// ---------------------------------------------------------------------------
package bmnc_defs;

    localparam int BMNC_N      = 8;
    localparam int BMNC_LOG_N  = 3;
    localparam int BMNC_ELEM_W = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } bmnc_state_e;

    function automatic int elem_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/bmnc_order_check.sv
// ---------------------------------------------------------------------------
// bmnc_order_check
// Tracks whether each of the two runs of a batch arrives in non-decreasing
// order. Holds the previously accepted element and a sticky error bit per run.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low
//   i_acc      in   element accepted this cycle
//   i_elem     in   accepted element (unsigned)
//   i_cnt      in   collect slot of the accepted element (MSB = run index)
//   i_clr      in   batch handed to the output register this cycle
//   o_err      out  sticky error pair including this cycle's accept;
//                   [0] = run 0, [1] = run 1
// ---------------------------------------------------------------------------
module bmnc_order_check
    import bmnc_defs::*;
#(
    parameter int log_N          = BMNC_LOG_N,
    parameter int elements_width = BMNC_ELEM_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_acc,
    input  logic [0:elements_width-1]   i_elem,
    input  logic [log_N:0]              i_cnt,
    input  logic                        i_clr,
    output logic [0:1]                  o_err
);

    logic [0:elements_width-1] r_prev;
    logic [0:1]                r_err;
    logic                      w_run_start;
    logic                      w_run;

    // Slot 0 of each run starts a fresh run: nothing to compare against.
    assign w_run_start = (i_cnt[log_N-1:0] == '0);
    assign w_run       = i_cnt[log_N];

    // The output already folds in the current element so the top can hand a
    // complete error pair to the output register on the last accept.
    always_comb begin
        o_err = r_err;
        if (i_acc && !w_run_start && (i_elem < r_prev)) begin
            o_err[w_run] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= '0;
            r_err  <= '0;
        end else begin
            if (i_acc) begin
                r_prev <= i_elem;
            end
            r_err <= i_clr ? 2'b00 : o_err;
        end
    end

endmodule

// File: rtl/bmnc_in_loader.sv
// ---------------------------------------------------------------------------
// bmnc_in_loader
// Streaming front-end for the bitonic merge network. Collects 2N elements
// (two N-element runs) into a wide vector, flags out-of-order runs, and
// presents the batch in an output register so the next batch can be
// collected while the current one drains.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low
//   in_elem    in   incoming element
//   in_valid   in   in_elem valid
//   in_ready   out  loader accepts this cycle (registered)
//   out        out  assembled vector, element k at [k*elements_width +: ...],
//                   element 0 at the MSB end
//   out_valid  out  out holds a complete batch
//   out_ready  in   consumer takes out this cycle
//   out_err    out  [0]: run 0 out of order, [1]: run 1 out of order
// ---------------------------------------------------------------------------
module bmnc_in_loader
    import bmnc_defs::*;
#(
    parameter int N              = BMNC_N,
    parameter int log_N          = BMNC_LOG_N,
    parameter int elements_width = BMNC_ELEM_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [0:elements_width-1]       in_elem,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [0:2*N*elements_width-1]   out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [0:1]                      out_err
);

    localparam int             CNT_W    = log_N + 1;
    localparam int             VEC_W    = 2 * N * elements_width;
    localparam logic [log_N:0] CNT_LAST = CNT_W'(2 * N - 1);
    localparam logic [log_N:0] CNT_ONE  = CNT_W'(1);

    bmnc_state_e         r_state;
    bmnc_state_e         w_state_next;
    logic [log_N:0]      r_cnt;
    logic [0:VEC_W-1]    r_coll;
    logic [0:VEC_W-1]    w_coll_next;
    logic [0:VEC_W-1]    r_out;
    logic [0:1]          r_out_err;
    logic                r_out_valid;
    logic                r_in_ready;
    logic                w_acc;
    logic                w_last;
    logic                w_slot_free;
    logic                w_transfer;
    logic [0:1]          w_err;

    assign w_acc       = in_valid && r_in_ready;
    assign w_last      = w_acc && (r_cnt == CNT_LAST);
    assign w_slot_free = !r_out_valid || out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: if (w_last && !w_slot_free) w_state_next = ST_FULL;
            ST_FULL: if (w_slot_free)            w_state_next = ST_FILL;
            default:                             w_state_next = ST_FILL;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_transfer = 1'b0;
        case (r_state)
            ST_FILL: w_transfer = w_last && w_slot_free;
            ST_FULL: w_transfer = w_slot_free;
            default: w_transfer = 1'b0;
        endcase
    end

    // in_ready is a flop so out_ready never reaches it combinationally; it
    // follows the state we are about to enter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == ST_FILL);
        end
    end

    // The collect vector as it will be after this edge; the last element of a
    // batch goes straight to the output register through this path.
    always_comb begin
        w_coll_next = r_coll;
        if (w_acc) begin
            w_coll_next[elem_off(int'(r_cnt), elements_width) +: elements_width] = in_elem;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_coll <= '0;
        end else begin
            r_coll <= w_coll_next;
            if (w_acc) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    bmnc_order_check #(
        .log_N          (log_N),
        .elements_width (elements_width)
    ) u_order_check (
        .clk    (clk),
        .reset  (reset),
        .i_acc  (w_acc),
        .i_elem (in_elem),
        .i_cnt  (r_cnt),
        .i_clr  (w_transfer),
        .o_err  (w_err)
    );

    // Output register: a transfer on the same edge as a drain keeps valid high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out       <= '0;
            r_out_err   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_transfer) begin
            r_out       <= w_coll_next;
            r_out_err   <= w_err;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out       = r_out;
    assign out_err   = r_out_err;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bmnc_in_loader.sv
module tb_bmnc_in_loader;

    logic        clk;
    logic        reset;
    logic [0:3]  in_elem;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] out;
    logic        out_valid;
    logic        out_ready;
    logic [0:1]  out_err;

    int total;
    int bad;
    int valid_cnt;
    bit ready_dropped;

    bmnc_in_loader #(
        .N              (8),
        .log_N          (3),
        .elements_width (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_elem   (in_elem),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Streams 16 elements, element 0 taken from the MSB nibble of v.
    task automatic feed(input logic [63:0] v, input bit gap);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_elem  = v[63-4*i -: 4];
            if (!in_ready) ready_dropped = 1'b1;
            tick();
            if (out_valid) valid_cnt++;
            if (gap && i < 15) begin
                in_valid = 1'b0;
                in_elem  = 4'h0;
                tick();
                if (out_valid) valid_cnt++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; in_elem = 4'h0; out_ready = 1'b0;
        tick(); tick(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out !== 64'h0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
        total++; if (out_err !== 2'b00) begin bad++; $display("FAIL reset_out_err got=%b want=00", out_err); end
        reset = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_stream;
        drain();
        feed(64'h01234567_01234567, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%0b want=1", out_valid); end
        total++; if (out !== 64'h01234567_01234567) begin bad++; $display("FAIL stream_out got=%h want=0123456701234567", out); end
        total++; if (out_err !== 2'b00) begin bad++; $display("FAIL stream_err got=%b want=00", out_err); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_drop got=%0b want=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        drain();
        valid_cnt = 0;
        ready_dropped = 1'b0;
        feed(64'h01234567_01234567, 1'b0);
        total++; if (out !== 64'h01234567_01234567) begin bad++; $display("FAIL b2b_out1 got=%h want=0123456701234567", out); end
        feed(64'h11223344_55667788, 1'b0);
        total++; if (out !== 64'h11223344_55667788) begin bad++; $display("FAIL b2b_out2 got=%h want=1122334455667788", out); end
        total++; if (out_err !== 2'b00) begin bad++; $display("FAIL b2b_err got=%b want=00", out_err); end
        total++; if (valid_cnt != 2) begin bad++; $display("FAIL b2b_valid_cycles got=%0d want=2", valid_cnt); end
        total++; if (ready_dropped) begin bad++; $display("FAIL b2b_in_ready got=dropped want=always_high"); end
    endtask

    task automatic test_order_err;
        drain();
        feed(64'h01234567_01253677, 1'b0);
        total++; if (out !== 64'h01234567_01253677) begin bad++; $display("FAIL order_out got=%h want=0123456701253677", out); end
        total++; if (out_err !== 2'b01) begin bad++; $display("FAIL order_err got=%b want=01", out_err); end
        feed(64'h01234567_01234567, 1'b0);
        total++; if (out_err !== 2'b00) begin bad++; $display("FAIL order_err_clear got=%b want=00", out_err); end
    endtask

    task automatic test_backpressure;
        drain();
        out_ready = 1'b0;
        feed(64'h76543210_01234567, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid1 got=%0b want=1", out_valid); end
        total++; if (out_err !== 2'b10) begin bad++; $display("FAIL bp_err1 got=%b want=10", out_err); end
        feed(64'h00112233_44556677, 1'b0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%0b want=0", in_ready); end
        tick(); tick();
        total++; if (out !== 64'h76543210_01234567) begin bad++; $display("FAIL bp_hold_out got=%h want=7654321001234567", out); end
        total++; if (out_err !== 2'b10) begin bad++; $display("FAIL bp_hold_err got=%b want=10", out_err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready got=%0b want=0", in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out !== 64'h00112233_44556677) begin bad++; $display("FAIL bp_out2 got=%h want=0011223344556677", out); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid2 got=%0b want=1", out_valid); end
        total++; if (out_err !== 2'b00) begin bad++; $display("FAIL bp_err2 got=%b want=00", out_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_in_ready got=%0b want=1", in_ready); end
        drain();
        feed(64'h01234567_01234567, 1'b0);
        total++; if (out !== 64'h01234567_01234567) begin bad++; $display("FAIL bp_after_out got=%h want=0123456701234567", out); end
    endtask

    task automatic test_gapped;
        drain();
        feed(64'hFEDCBA98_FEDCBA98, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%0b want=1", out_valid); end
        total++; if (out !== 64'hFEDCBA98_FEDCBA98) begin bad++; $display("FAIL gap_out got=%h want=FEDCBA98FEDCBA98", out); end
        total++; if (out_err !== 2'b11) begin bad++; $display("FAIL gap_err got=%b want=11", out_err); end
    endtask

    task automatic test_reset_mid;
        logic [19:0] part;
        part = 20'h98765;
        drain();
        out_ready = 1'b0;
        feed(64'h01234567_01234567, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_elem  = part[19-4*i -: 4];
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", out_valid); end
        total++; if (out !== 64'h0) begin bad++; $display("FAIL rmid_out got=%h want=0", out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready got=%0b want=0", in_ready); end
        reset = 1'b1;
        tick();
        out_ready = 1'b1;
        valid_cnt = 0;
        feed(64'h01234567_01234567, 1'b0);
        total++; if (out !== 64'h01234567_01234567) begin bad++; $display("FAIL rmid_new_out got=%h want=0123456701234567", out); end
        total++; if (out_err !== 2'b00) begin bad++; $display("FAIL rmid_new_err got=%b want=00", out_err); end
        total++; if (valid_cnt != 1) begin bad++; $display("FAIL rmid_valid_cycles got=%0d want=1", valid_cnt); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        valid_cnt = 0;
        ready_dropped = 1'b0;
        test_reset();
        test_stream();
        test_back_to_back();
        test_order_err();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bmnc_in_loader.md
# bmnc_in_loader

Streaming front-end for the bitonic merge network (BMNC). It accepts one `elements_width`-bit element per cycle over a valid/ready handshake and assembles two N-element runs into the 2N-element wide vector the merge network consumes. Each run is checked for non-decreasing order. The finished vector is held in an output register with its own valid/ready handshake, so collection of the next batch overlaps with draining of the current one.

## Interface
- `N`, 8, elements per run (power of two)
- `log_N`, 3, log2(N)
- `elements_width`, 4, bits per element (unsigned)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low (reset=0 resets)
- `in_elem`  in  [0:elements_width-1]  incoming element
- `in_valid`  in  1  `in_elem` valid
- `in_ready`  out  1  loader can accept this cycle
- `out`  out  [0:2*N*elements_width-1]  assembled vector; element k at bits [k*elements_width +: elements_width]; element 0 at MSB end
- `out_valid`  out  1  `out` holds a complete batch
- `out_ready`  in  1  consumer takes `out` this cycle
- `out_err`  out  [0:1]  bit0: run 0 (elements 0..N-1) not non-decreasing; bit1: run 1 (elements N..2N-1)

## Operation
- Accept on `in_valid && in_ready` at rising edge; write to collect register slot `cnt`; `cnt` (log_N+1 bits) increments, wraps 2N-1 -> 0.
- Order check: for each accepted element with `cnt mod N != 0`, compare to previous accepted element; if smaller, set sticky collect-error bit for run `cnt/N`. Equal is legal. `cnt mod N == 0` starts a fresh run with no comparison.
- Output slot free := `!out_valid || out_ready`.
- Transfer: collect data+errors -> `out`/`out_err`, `out_valid`=1, collect errors cleared. Happens at the edge where the batch completes (last element accepted) if slot free, else at the first later edge with slot free.
- State machine:
  - FILL: `in_ready`=1. Last element accepted and slot free -> transfer, stay FILL. Last element accepted and slot busy -> FULL.
  - FULL: `in_ready`=0. Slot free -> transfer, go to FILL.
- `out_valid` drops after an `out_ready` handshake unless a transfer occurs on that same edge (then it stays 1 with new data).
- `out`/`out_err` are stable while `out_valid && !out_ready`.
- Reset mid-batch: partial batch and errors are discarded; pending output is dropped.

## Timing
- Reset values: `cnt`=0, state=FILL, `out`=0, `out_err`=0, `out_valid`=0, collect register=0, collect errors=0. `in_ready`=0 while reset=0, 1 in the first cycle after release.
- Latency: last element accepted at edge t -> `out_valid`=1 after edge t (zero bubble) when the slot is free.
- Throughput: 1 element/cycle sustained with `out_ready` held 1; one batch per 2N cycles, `in_ready` never drops.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`. A FULL->FILL transfer at edge t gives `in_ready`=1 after t (one stall cycle minimum).
- `in_valid`=0 cycles insert holes; `cnt` holds.

## Structure
- Shared package/header `bmnc_defs`:
  - FILL/FULL state encodings
  - element slice-offset helper (k*elements_width)
  - default N/log_N/elements_width, shared with `BMNC_random` instances
- Sub-module `bmnc_order_check`: registered previous element, run-start flag and sticky error pair. Takes accept strobe, element, `cnt`, and clear-on-transfer; outputs the error pair.
- Top holds the counter, collect register, output register and FSM; ~150-250 lines.

## Test plan
- Post-reset: reset=0 for 3 cycles -> `in_ready`=0, `out_valid`=0, `out`=0. Release -> `in_ready`=1 next cycle.
- Stream 0,1,..,7,0,1,..,7 back-to-back, `out_ready`=1 -> `out`=64'h01234567_01234567, `out_err`=2'b00, `out_valid` high exactly one cycle, right after 16th accept.
- Run 1 = 0,1,2,5,3,6,7,7 (run 0 sorted) -> `out_err`=2'b01 (bit1 set, bit0 clear). Duplicate 7,7 is not an error. Next clean batch has `out_err`=2'b00.
- Backpressure: `out_ready`=0, stream two full batches -> first batch held stable. Second completes -> FULL, `in_ready`=0. Raise `out_ready` one cycle -> second batch appears next cycle, `in_ready`=1 afterwards, no element lost.
- Gapped input: `in_valid` toggled 1/0 with pattern F,E,D,C,B,A,9,8 x2 -> `out`=64'hFEDCBA98_FEDCBA98, `out_err`=2'b11.
- Reset after 5 accepted elements, then a full 0..7,0..7 batch -> `out` equals the new batch only; the first 5 elements do not appear.
